// File: rtl/pe_config_loader.sv
// Assembles 8-bit PE control words from a low-nibble-first stream, writes each one with a
// single-cycle per-PE enable pulse, then enables every PE. Optional parity nibble: CFG_PARITY_EN.
module pe_config_loader #(
  parameter int NUM_PE = 4,
  parameter int CTRL_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       halt,
  input  logic                       cfg_valid,
  input  logic [3:0]                 cfg_nibble,
  output logic                       cfg_ready,
  output logic [NUM_PE*CTRL_W-1:0]   ctrl_out,
  output logic [NUM_PE-1:0]          pe_en,
  output logic                       run,
  output logic                       cfg_err
);
  localparam int IDXW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDXW-1:0]   LAST = IDXW'(NUM_PE - 1);
  localparam logic [NUM_PE-1:0] ONE  = NUM_PE'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_COMMIT, S_RUN
`ifdef CFG_PARITY_EN
    , S_PAR, S_ERROR
`endif
  } state_t;

  state_t                         r_state;
  logic [IDXW-1:0]                r_idx;
  logic [3:0]                     r_lo;
  logic [NUM_PE-1:0][CTRL_W-1:0]  r_ctrl;
  logic [NUM_PE-1:0]              r_pe_en;
  logic                           r_run;
  logic                           w_xfer;
  logic [NUM_PE-1:0]              w_onehot;
`ifdef CFG_PARITY_EN
  logic [3:0]                     r_hi;
  logic                           r_err;
`endif

  always_comb begin
    cfg_ready = 1'b0;
    case (r_state)
      S_LO, S_HI: cfg_ready = 1'b1;
`ifdef CFG_PARITY_EN
      S_PAR:      cfg_ready = 1'b1;
`endif
      default:    cfg_ready = 1'b0;
    endcase
  end

  assign w_xfer   = cfg_valid && cfg_ready;
  assign w_onehot = ONE << r_idx;
  assign ctrl_out = r_ctrl;
  assign pe_en    = r_pe_en;
  assign run      = r_run;
`ifdef CFG_PARITY_EN
  assign cfg_err  = r_err;
`else
  assign cfg_err  = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_lo    <= '0;
      r_ctrl  <= '0;
      r_pe_en <= '0;
      r_run   <= 1'b0;
`ifdef CFG_PARITY_EN
      r_hi    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (!halt && start) begin
          r_state <= S_LO;
          r_idx   <= '0;
        end
        S_LO: begin
          if (halt) r_state <= S_IDLE;
          else if (w_xfer) begin
            r_lo    <= cfg_nibble;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (halt) r_state <= S_IDLE;
          else if (w_xfer) begin
`ifdef CFG_PARITY_EN
            r_hi    <= cfg_nibble;
            r_state <= S_PAR;
`else
            // Word and its enable pulse land on the same edge; the PE samples on the next one.
            r_ctrl[r_idx] <= {cfg_nibble, r_lo};
            r_pe_en       <= w_onehot;
            r_state       <= S_COMMIT;
`endif
          end
        end
`ifdef CFG_PARITY_EN
        S_PAR: begin
          if (halt) r_state <= S_IDLE;
          else if (w_xfer) begin
            if (cfg_nibble[0] == ^{r_hi, r_lo}) begin
              r_ctrl[r_idx] <= {r_hi, r_lo};
              r_pe_en       <= w_onehot;
              r_state       <= S_COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_pe_en <= '0;
              r_state <= S_ERROR;
            end
          end
        end
        S_ERROR: if (!halt && start) begin
          r_err   <= 1'b0;
          r_idx   <= '0;
          r_state <= S_LO;
        end
`endif
        S_COMMIT: begin
          if (halt) begin
            r_pe_en <= '0;
            r_state <= S_IDLE;
          end else if (r_idx == LAST) begin
            r_pe_en <= '1;
            r_run   <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_pe_en <= '0;
            r_idx   <= r_idx + IDXW'(1);
            r_state <= S_LO;
          end
        end
        S_RUN: if (halt) begin
          r_pe_en <= '0;
          r_run   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
